// File: rtl/rv32i_pkg.sv
// Shared core definitions: CSR addresses, interrupt debounce FSM encoding
// and default parameters for the external interrupt controller.
package rv32i_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // Interrupt controller defaults
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    // Saturation value of the missed-event counter
    localparam logic [7:0] MISSED_MAX = 8'hFF;

    // Debounce FSM states
    typedef enum logic [1:0] {
        LOW      = 2'b00,
        CHK_HIGH = 2'b01,
        HIGH     = 2'b10,
        CHK_LOW  = 2'b11
    } db_state_e;

endpackage

// File: rtl/irq_controller_if.sv
// Signal bundle between the interrupt controller and its surroundings
// (external line, CSR enable, trap acknowledge, request/status outputs).
interface irq_controller_if;

    logic       key_raw;
    logic       mie_en;
    logic       ack;
    logic       key;
    logic       pending;
    logic [7:0] missed_cnt;

    modport master (
        output key_raw,
        output mie_en,
        output ack,
        input  key,
        input  pending,
        input  missed_cnt
    );

    modport slave (
        input  key_raw,
        input  mie_en,
        input  ack,
        output key,
        output pending,
        output missed_cnt
    );

endinterface

// File: rtl/irq_controller_key_debounce.sv
// Debounce FSM for the synchronized interrupt line. A level change is
// accepted only after the new level has been seen for a run of consecutive
// samples; an accepted rising change produces a one-cycle rise pulse.
module key_debounce
    import rv32i_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_q,
    output logic level,
    output logic rise
);

    localparam logic [15:0] CNT_LIMIT = 16'(DEBOUNCE_CYCLES);

    db_state_e   state;
    logic [15:0] cnt;

    // State and stability counter advance on every sample of sync_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOW;
            cnt   <= 16'd0;
        end else begin
            case (state)
                LOW: begin
                    if (sync_q) begin
                        state <= CHK_HIGH;
                        cnt   <= 16'd1;
                    end
                end
                CHK_HIGH: begin
                    if (!sync_q) begin
                        state <= LOW;
                        cnt   <= 16'd0;
                    end else if (cnt == CNT_LIMIT) begin
                        state <= HIGH;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HIGH: begin
                    if (!sync_q) begin
                        state <= CHK_LOW;
                        cnt   <= 16'd1;
                    end
                end
                CHK_LOW: begin
                    if (sync_q) begin
                        state <= HIGH;
                        cnt   <= 16'd0;
                    end else if (cnt == CNT_LIMIT) begin
                        state <= LOW;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= LOW;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

    // Decoded from registers only (state, cnt and the last synchronizer
    // stage), so the pulse is glitch-free and lands in the same cycle the
    // FSM commits to HIGH, letting pending set on that edge.
    assign rise  = (state == CHK_HIGH) && sync_q && (cnt == CNT_LIMIT);
    assign level = (state == HIGH) || (state == CHK_LOW);

endmodule

// File: rtl/irq_controller.sv
// External interrupt controller: synchronizes and debounces the raw line,
// latches accepted rising edges as pending until the trap is acknowledged,
// counts edges lost while already pending, and gates the request with mie.
module irq_controller
    import rv32i_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    irq_controller_if.slave bus
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    logic                   rise;
    logic                   level_unused;
    logic                   pending_q;
    logic                   key_q;
    logic [7:0]             missed_q;

    // Metastability chain for the asynchronous line; nothing else sees key_raw
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], bus.key_raw};
        end
    end

    assign sync_q = sync_ff[SYNC_STAGES-1];

    // The debounced level itself is not needed here, only its rising edge
    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .sync_q (sync_q),
        .level  (level_unused),
        .rise   (rise)
    );

    // Pending flag: a new edge wins over a simultaneous acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
        end else if (rise) begin
            pending_q <= 1'b1;
        end else if (bus.ack) begin
            pending_q <= 1'b0;
        end
    end

    // Count edges that arrive while an unserviced event is still pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            missed_q <= 8'd0;
        end else if (rise && pending_q && !bus.ack && (missed_q != MISSED_MAX)) begin
            missed_q <= missed_q + 8'd1;
        end
    end

    // Registered request towards the CSR block, masked by the enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= 1'b0;
        end else begin
            key_q <= pending_q & bus.mie_en;
        end
    end

    assign bus.key        = key_q;
    assign bus.pending    = pending_q;
    assign bus.missed_cnt = missed_q;

endmodule
